// File: rtl/cdb_arbiter_if.sv
// Result-producer to CDB-arbiter bundle: per-source result pulses in, one
// registered broadcast plus near-full and overflow status out.
interface cdb_arbiter_if #(
  parameter int N_SRC  = 3,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
);
  logic                      _clear;
  logic [N_SRC-1:0]          _src_valid;
  logic [N_SRC*ROB_W-1:0]    _src_rob_id;
  logic [N_SRC*DATA_W-1:0]   _src_value;
  logic [N_SRC-1:0]          _src_full;
  logic                      _cdb_ready;
  logic [ROB_W-1:0]          _cdb_rob_id;
  logic [DATA_W-1:0]         _cdb_value;
  logic                      _overflow;

  modport master (
    output _clear, _src_valid, _src_rob_id, _src_value,
    input  _src_full, _cdb_ready, _cdb_rob_id, _cdb_value, _overflow
  );

  modport slave (
    input  _clear, _src_valid, _src_rob_id, _src_value,
    output _src_full, _cdb_ready, _cdb_rob_id, _cdb_value, _overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-source result FIFOs drained round-robin onto the common data bus,
// at most one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_id;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t           mem    [N_SRC][DEPTH];
  logic [PTR_W-1:0] rd_ptr [N_SRC];
  logic [PTR_W-1:0] wr_ptr [N_SRC];
  logic [CNT_W-1:0] count  [N_SRC];
  logic [SRC_W-1:0] rr_ptr;

  logic             grant;
  logic [SRC_W-1:0] winner;
  logic [N_SRC-1:0] do_push;
  logic [N_SRC-1:0] do_pop;
  logic [N_SRC-1:0] push_drop;
  logic [N_SRC-1:0] src_full;

  logic             cdb_ready_q;
  entry_t           cdb_q;
  logic             overflow_q;

  // Candidates are judged on counts before this edge's push, so a fresh
  // pulse can never be broadcast in the cycle it arrives.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant && count[SRC_W'(idx)] != '0) begin
        grant  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      do_pop[i]    = grant && (winner == SRC_W'(i));
      push_drop[i] = bus._src_valid[i] && (count[i] == CNT_W'(DEPTH));
      do_push[i]   = bus._src_valid[i] && !push_drop[i];
      // One entry early: the pulse already in flight still has a slot.
      src_full[i]  = count[i] >= CNT_W'(DEPTH - 1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < N_SRC; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr      <= '0;
      cdb_ready_q <= 1'b0;
      cdb_q       <= '0;
      overflow_q  <= 1'b0;
    end else if (rdy_in) begin
      if (bus._clear) begin
        for (int i = 0; i < N_SRC; i++) begin
          count[i]  <= '0;
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
        end
        cdb_ready_q <= 1'b0;
      end else begin
        for (int i = 0; i < N_SRC; i++) begin
          if (do_push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
          if (do_pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          count[i] <= count[i] + CNT_W'(do_push[i]) - CNT_W'(do_pop[i]);
        end
        if (|push_drop) overflow_q <= 1'b1;
        if (grant) begin
          cdb_ready_q <= 1'b1;
          cdb_q       <= mem[winner][rd_ptr[winner]];
          rr_ptr      <= (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + SRC_W'(1);
        end else begin
          cdb_ready_q <= 1'b0;
        end
      end
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked by the counts and pointers alone.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (rst_in && rdy_in && !bus._clear && do_push[i]) begin
        mem[i][wr_ptr[i]] <= {bus._src_rob_id[i*ROB_W +: ROB_W],
                              bus._src_value[i*DATA_W +: DATA_W]};
      end
    end
  end

  assign bus._src_full   = src_full;
  assign bus._cdb_ready  = cdb_ready_q;
  assign bus._cdb_rob_id = cdb_q.rob_id;
  assign bus._cdb_value  = cdb_q.value;
  assign bus._overflow   = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin contention,
// near-full/overflow, flush and stall, all against hand-derived values.
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_arbiter_if #(.N_SRC(3), .ROB_W(5), .DATA_W(32)) bus ();

  cdb_arbiter #(.N_SRC(3), .DEPTH(4), .ROB_W(5), .DATA_W(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change only here.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] rob, input logic [31:0] val);
    bus._src_valid[i]          = 1'b1;
    bus._src_rob_id[i*5 +: 5]  = rob;
    bus._src_value[i*32 +: 32] = val;
  endtask

  task automatic push(input int i, input logic [4:0] rob);
    set_src(i, rob, 32'h1000 + 32'(rob));
  endtask

  task automatic expect_bcast(input string tag, input logic [4:0] rob);
    check({tag, ".ready"}, bus._cdb_ready, 1'b1);
    check({tag, ".rob"},   bus._cdb_rob_id, rob);
    check({tag, ".value"}, bus._cdb_value, 32'h1000 + 32'(rob));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".ready"}, bus._cdb_ready, 1'b0);
  endtask

  initial begin
    rst_in          = 1'b0;
    rdy_in          = 1'b1;
    bus._clear      = 1'b0;
    bus._src_valid  = 3'b111;
    bus._src_rob_id = '1;
    bus._src_value  = '1;

    // Reset held two edges with pulses present.
    step();
    step();
    check("rst.ready", bus._cdb_ready, 1'b0);
    check("rst.rob",   bus._cdb_rob_id, 5'd0);
    check("rst.value", bus._cdb_value, 32'd0);
    check("rst.ovf",   bus._overflow, 1'b0);
    check("rst.full",  bus._src_full, 3'b000);
    rst_in = 1'b1;
    bus._src_valid = '0;
    step();
    expect_idle("rst.after");

    // Single ALU pulse: visible after E+1 only.
    set_src(0, 5'd5, 32'h1234);
    step();
    expect_idle("lat.e0");
    bus._src_valid = '0;
    step();
    check("lat.e1.ready", bus._cdb_ready, 1'b1);
    check("lat.e1.rob",   bus._cdb_rob_id, 5'd5);
    check("lat.e1.value", bus._cdb_value, 32'h1234);
    step();
    expect_idle("lat.e2");
    check("lat.e2.rob", bus._cdb_rob_id, 5'd5);

    // Spare source once so the round-robin pointer returns to 0.
    push(2, 5'd9);
    step();
    bus._src_valid = '0;
    step();
    expect_bcast("spare", 5'd9);
    step();
    expect_idle("spare.end");

    // Contention: all three at one edge, then a second burst.
    push(0, 5'd1); push(1, 5'd2); push(2, 5'd3);
    step();
    expect_idle("cont.push");
    bus._src_valid = '0;
    step(); expect_bcast("cont.a", 5'd1);
    step(); expect_bcast("cont.b", 5'd2);
    step(); expect_bcast("cont.c", 5'd3);
    step(); expect_idle("cont.end");
    push(0, 5'd4); push(1, 5'd5); push(2, 5'd6);
    step();
    bus._src_valid = '0;
    step(); expect_bcast("wrap.a", 5'd4);
    step(); expect_bcast("wrap.b", 5'd5);
    step(); expect_bcast("wrap.c", 5'd6);
    step(); expect_idle("wrap.end");

    // LSB fills while ALU and spare compete; sixth LSB pulse is dropped.
    push(0, 5'd10); push(1, 5'd20); push(2, 5'd30);
    step(); expect_idle("ovf.e1");
    check("ovf.e1.full", bus._src_full, 3'b000);
    bus._src_valid = '0;
    push(0, 5'd11); push(1, 5'd21); push(2, 5'd31);
    step(); expect_bcast("ovf.e2", 5'd10);
    check("ovf.e2.full", bus._src_full, 3'b000);
    bus._src_valid = '0;
    push(1, 5'd22);
    step(); expect_bcast("ovf.e3", 5'd20);
    check("ovf.e3.full", bus._src_full, 3'b000);
    push(1, 5'd23);
    step(); expect_bcast("ovf.e4", 5'd30);
    check("ovf.e4.full", bus._src_full, 3'b010);
    push(1, 5'd24);
    step(); expect_bcast("ovf.e5", 5'd11);
    check("ovf.e5.full", bus._src_full, 3'b010);
    check("ovf.e5.ovf",  bus._overflow, 1'b0);
    push(1, 5'd25);
    step(); expect_bcast("ovf.e6", 5'd21);
    check("ovf.e6.full", bus._src_full, 3'b010);
    check("ovf.e6.ovf",  bus._overflow, 1'b1);
    bus._src_valid = '0;
    step(); expect_bcast("ovf.e7", 5'd31);
    check("ovf.e7.full", bus._src_full, 3'b010);
    step(); expect_bcast("ovf.e8", 5'd22);
    check("ovf.e8.full", bus._src_full, 3'b000);
    step(); expect_bcast("ovf.e9", 5'd23);
    step(); expect_bcast("ovf.e10", 5'd24);
    step(); expect_idle("ovf.end");
    check("ovf.sticky", bus._overflow, 1'b1);

    // Flush with entries queued and a same-cycle ALU pulse.
    push(0, 5'd16); push(1, 5'd17); push(2, 5'd18);
    step(); expect_idle("fl.f1");
    bus._src_valid = '0;
    push(0, 5'd12); push(1, 5'd13); push(2, 5'd14);
    step(); expect_bcast("fl.f2", 5'd18);
    bus._src_valid = '0;
    bus._clear = 1'b1;
    set_src(0, 5'd7, 32'h7777);
    step();
    expect_idle("fl.clear");
    check("fl.clear.full", bus._src_full, 3'b000);
    check("fl.clear.rob",  bus._cdb_rob_id, 5'd18);
    bus._clear = 1'b0;
    bus._src_valid = '0;
    step(); expect_idle("fl.after");
    check("fl.after.ovf", bus._overflow, 1'b1);
    step(); expect_idle("fl.after2");

    // Stall mid-drain: state frozen and pulses ignored.
    push(0, 5'd26); push(1, 5'd27); push(2, 5'd28);
    step(); expect_idle("st.push");
    bus._src_valid = '0;
    step(); expect_bcast("st.first", 5'd26);
    rdy_in = 1'b0;
    push(0, 5'd1); push(1, 5'd2); push(2, 5'd3);
    for (int s = 0; s < 3; s++) begin
      step();
      expect_bcast("st.hold", 5'd26);
      check("st.hold.full", bus._src_full, 3'b000);
    end
    rdy_in = 1'b1;
    bus._src_valid = '0;
    step(); expect_bcast("st.res.a", 5'd27);
    step(); expect_bcast("st.res.b", 5'd28);
    step(); expect_idle("st.end");

    // Only reset clears the sticky overflow.
    rst_in = 1'b0;
    step();
    check("rst2.ovf",   bus._overflow, 1'b0);
    check("rst2.ready", bus._cdb_ready, 1'b0);
    check("rst2.rob",   bus._cdb_rob_id, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
